sdram_init_refresh: RTL and testbench
=====================================

Name: sdram_init_refresh

Overview:
Sequences SDRAM power-up initialisation and schedules periodic auto-refresh for the sdram controller. Owns the SDRAM command bus during init and refresh. Hands the bus to the read/write controller through a req/gnt handshake. Top level muxes cmd/a/ba using own_bus.

Parameters:
T_POWERUP, 14300, NOP cycles after reset before first command (100 us @ 143 MHz)
T_RP, 3, cycles from PRECHARGE to next command
T_RFC, 9, cycles from AUTO REFRESH to next command
T_MRD, 2, cycles from LOAD MODE to init_done
REFRESH_INTERVAL, 1100, cycles between refresh deadlines (7.8 us)
MODE, 13'h030, mode register value (CL3, sequential, burst 1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cmd  out  4  {CSn,RASn,CASn,WEn} command code
cke  out  1  SDRAM clock enable
ba  out  2  bank address
a  out  13  address bus
own_bus  out  1  this block drives cmd/a/ba
init_done  out  1  init complete, sticky until reset
ref_req  out  1  refresh pending, requesting bus
ref_gnt  in  1  controller idle, all banks precharged, bus released
ref_done  out  1  one-cycle pulse after refresh tRFC elapses
ref_overrun  out  1  sticky: backlog saturated

Behaviour:
- Reset values: cmd=NOP (4'b0111), cke=0, ba=0, a=0, own_bus=1, init_done=0, ref_req=0, ref_done=0, ref_overrun=0, backlog=0, state=POWERUP.
- Reset is asynchronous; asserting it mid-sequence aborts immediately and restarts from POWERUP.
- All outputs are registered. Non-NOP commands last exactly one cycle, and cmd=NOP otherwise.
- Timing rule: a command in cycle n allows the next command no earlier than cycle n+T, using a wait counter loaded with T-1.
- POWERUP: cke=1 from the first cycle after reset release. Emit NOP for T_POWERUP cycles, then go to PRE.
- PRE: PRECHARGE (0010) with a[10]=1 (all banks). Wait T_RP, then REF1.
- REF1: REFRESH (0001). Wait T_RFC, then REF2.
- REF2: REFRESH. Wait T_RFC, then LMR.
- LMR: LOAD MODE (0000) with a=MODE and ba=0. Wait T_MRD.
- Then IDLE: init_done=1 and own_bus=0.
- Refresh timer:
  - Starts when init_done rises and reloads every REFRESH_INTERVAL cycles.
  - Each expiry increments a 3-bit backlog.
  - At backlog=7, a further expiry sets ref_overrun and backlog stays 7.
  - Expiry and decrement in the same cycle leave backlog unchanged.
- IDLE with backlog>0: ref_req=1 and go to REQ.
- REQ: hold ref_req until ref_gnt is sampled 1, then go to AREF.
- AREF: own_bus=1, REFRESH, backlog decrement, ref_req=0. Wait T_RFC.
- Completion: pulse ref_done and set own_bus=0 in the same cycle. Return to IDLE, then issue the next REQ immediately if backlog>0.
- ref_gnt is ignored outside REQ.
- ref_gnt dropping while in REQ keeps the block waiting; the request is never withdrawn.

Decomposition:
- Shared include sdram_defs.vh holds the command code constants (LoadMode, Refresh, Precharge, Active, Write, Read, Terminate, Nop, Unselect). sdram and this block both use it.
- One sub-module, sdram_refresh_timer: interval down-counter, saturating backlog, overrun flag, with inc/dec interface.
- The FSM and wait counter stay in the top-level block.

Test Plan:
- Params 20/3/9/2/100. Release reset at cycle 0 -> PRECHARGE with a[10]=1 at cycle 20, REFRESH at 23 and 32, LOAD MODE with a=0x030 at 41, init_done=1 at 43, no other non-NOP cmd.
- ref_gnt tied 1 -> ref_req at 143, REFRESH at 144, ref_done at 153 with own_bus=0; repeats every 100 cycles.
- ref_gnt held 0 for 350 cycles after init -> backlog=3. On grant: three REFRESH commands 10 cycles apart, ref_done pulses three times, ref_overrun=0.
- ref_gnt held 0 for 800 cycles -> ref_overrun=1 after the 8th expiry. Backlog stays 7, and 7 refreshes are drained once granted.
- rstn low at cycle 30 (mid REF1 wait) -> immediately cmd=NOP, cke=0, init_done=0. After release, the full sequence restarts with PRECHARGE 20 cycles later.
- Timer expiry coincident with the AREF decrement -> backlog unchanged, no lost or extra refresh.

Source files
------------

// File: rtl/sdram_init_refresh_pkg.sv
// SDRAM init/refresh shared definitions: command codes, FSM states,
// and a width helper for the wait counter.
package sdram_init_refresh_pkg;

    // {CSn, RASn, CASn, WEn}
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_BST  = 4'b0110;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_DESL = 4'b1111;

    localparam logic [12:0] A10_ALL = 13'h0400;

    // Each state names the command already issued whose
    // timing window is being waited out.
    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_PRE,
        ST_REF1,
        ST_REF2,
        ST_LMR,
        ST_IDLE,
        ST_REQ,
        ST_AREF
    } state_t;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_refresh_if.sv
// Command bus and refresh handshake between the init/refresh block
// (master) and the SDRAM controller (slave).
interface sdram_init_refresh_if;
    logic [3:0]  cmd;
    logic        cke;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        own_bus;
    logic        init_done;
    logic        ref_req;
    logic        ref_gnt;
    logic        ref_done;
    logic        ref_overrun;

    modport master (
        output cmd, cke, ba, a, own_bus,
        output init_done, ref_req, ref_done, ref_overrun,
        input  ref_gnt
    );

    modport slave (
        input  cmd, cke, ba, a, own_bus,
        input  init_done, ref_req, ref_done, ref_overrun,
        output ref_gnt
    );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Refresh deadline timer with 3-bit saturating backlog and sticky overrun.
// Ports: clk, rstn, en (timer runs), dec (refresh taken), backlog, overrun.
module sdram_refresh_timer #(
    parameter int INTERVAL = 1100
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       dec,
    output logic [2:0] backlog,
    output logic       overrun
);

    localparam int CNT_W = $clog2(INTERVAL);

    // The first interval is counted from the cycle en rises, which
    // is one cycle before the counter first sees en; start one short.
    localparam logic [CNT_W-1:0] START  = CNT_W'(INTERVAL - 2);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign expire = en && (cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= START;
            backlog <= '0;
            overrun <= 1'b0;
        end else begin
            if (!en)
                cnt <= START;
            else if (cnt == '0)
                cnt <= RELOAD;
            else
                cnt <= cnt - 1'b1;

            unique case ({expire, dec})
                2'b10: begin
                    if (backlog == 3'd7)
                        overrun <= 1'b1;
                    else
                        backlog <= backlog + 3'd1;
                end
                2'b01: begin
                    if (backlog != 3'd0)
                        backlog <= backlog - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init sequencer and auto-refresh scheduler.
// Ports: clk, rstn, bus (cmd/cke/ba/a/own_bus, init/refresh handshake).
module sdram_init_refresh
    import sdram_init_refresh_pkg::*;
#(
    parameter int          T_POWERUP        = 14300,
    parameter int          T_RP             = 3,
    parameter int          T_RFC            = 9,
    parameter int          T_MRD            = 2,
    parameter int          REFRESH_INTERVAL = 1100,
    parameter logic [12:0] MODE             = 13'h030
) (
    input  logic                 clk,
    input  logic                 rstn,
    sdram_init_refresh_if.master bus
);

    localparam int WAIT_W =
        $clog2(max4(T_POWERUP, T_RP, T_RFC, T_MRD) + 1);

    localparam logic [WAIT_W-1:0] LD_RP  = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] LD_RFC = WAIT_W'(T_RFC - 1);
    localparam logic [WAIT_W-1:0] LD_MRD = WAIT_W'(T_MRD - 1);

    state_t            state;
    logic [WAIT_W-1:0] wcnt;
    logic [3:0]        cmd;
    logic              cke;
    logic [1:0]        ba;
    logic [12:0]       a;
    logic              own_bus;
    logic              init_done;
    logic              ref_req;
    logic              ref_done;
    logic [2:0]        backlog;
    logic              overrun;
    logic              ref_take;

    // The grant is consumed on the same edge the REFRESH is issued.
    assign ref_take = (state == ST_REQ) && bus.ref_gnt;

    sdram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .en      (init_done),
        .dec     (ref_take),
        .backlog (backlog),
        .overrun (overrun)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_POWERUP;
            // Counts T_POWERUP NOP cycles after release before PRECHARGE.
            wcnt      <= WAIT_W'(T_POWERUP);
            cmd       <= CMD_NOP;
            cke       <= 1'b0;
            ba        <= '0;
            a         <= '0;
            own_bus   <= 1'b1;
            init_done <= 1'b0;
            ref_req   <= 1'b0;
            ref_done  <= 1'b0;
        end else begin
            cmd      <= CMD_NOP;
            ba       <= '0;
            a        <= '0;
            ref_done <= 1'b0;
            cke      <= 1'b1;

            if (wcnt != '0)
                wcnt <= wcnt - 1'b1;

            unique case (state)
                ST_POWERUP: begin
                    if (wcnt == '0) begin
                        cmd   <= CMD_PRE;
                        a     <= A10_ALL;
                        wcnt  <= LD_RP;
                        state <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (wcnt == '0) begin
                        cmd   <= CMD_REF;
                        wcnt  <= LD_RFC;
                        state <= ST_REF1;
                    end
                end
                ST_REF1: begin
                    if (wcnt == '0) begin
                        cmd   <= CMD_REF;
                        wcnt  <= LD_RFC;
                        state <= ST_REF2;
                    end
                end
                ST_REF2: begin
                    if (wcnt == '0) begin
                        cmd   <= CMD_LMR;
                        a     <= MODE;
                        wcnt  <= LD_MRD;
                        state <= ST_LMR;
                    end
                end
                ST_LMR: begin
                    if (wcnt == '0) begin
                        init_done <= 1'b1;
                        own_bus   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (backlog != 3'd0) begin
                        ref_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.ref_gnt) begin
                        own_bus <= 1'b1;
                        cmd     <= CMD_REF;
                        ref_req <= 1'b0;
                        wcnt    <= LD_RFC;
                        state   <= ST_AREF;
                    end
                end
                ST_AREF: begin
                    if (wcnt == '0) begin
                        ref_done <= 1'b1;
                        own_bus  <= 1'b0;
                        // Re-request straight away so queued refreshes
                        // drain back to back.
                        if (backlog != 3'd0) begin
                            ref_req <= 1'b1;
                            state   <= ST_REQ;
                        end else begin
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_POWERUP;
            endcase
        end
    end

    assign bus.cmd         = cmd;
    assign bus.cke         = cke;
    assign bus.ba          = ba;
    assign bus.a           = a;
    assign bus.own_bus     = own_bus;
    assign bus.init_done   = init_done;
    assign bus.ref_req     = ref_req;
    assign bus.ref_done    = ref_done;
    assign bus.ref_overrun = overrun;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh with short timing parameters.
// Cycle c is the output state sampled 1ns after the c-th edge past reset.
module tb_sdram_init_refresh;
    import sdram_init_refresh_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    sdram_init_refresh_if bus ();

    sdram_init_refresh #(
        .T_POWERUP        (20),
        .T_RP             (3),
        .T_RFC            (9),
        .T_MRD            (2),
        .REFRESH_INTERVAL (100),
        .MODE             (13'h030)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_cmd", bus.cmd, CMD_NOP);
        chk("rst_cke", bus.cke, 0);
        chk("rst_ba", bus.ba, 0);
        chk("rst_a", bus.a, 0);
        chk("rst_own", bus.own_bus, 1);
        chk("rst_init", bus.init_done, 0);
        chk("rst_req", bus.ref_req, 0);
        chk("rst_done", bus.ref_done, 0);
        chk("rst_ovr", bus.ref_overrun, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rstn = 1'b1;
        cyc = -1;
    endtask

    function automatic logic [3:0] init_cmd(int c);
        if (c == 20) return CMD_PRE;
        if (c == 23 || c == 32) return CMD_REF;
        if (c == 41) return CMD_LMR;
        return CMD_NOP;
    endfunction

    initial begin
        logic [3:0] e;
        int nref;
        int ndone;

        // Init sequence, then periodic refresh with grant tied high.
        bus.ref_gnt = 1'b1;
        do_reset();
        for (int c = 0; c <= 260; c++) begin
            tick();
            e = init_cmd(c);
            if (c == 144 || c == 244) e = CMD_REF;
            chk("a_cmd", bus.cmd, e);
            chk("a_cke", bus.cke, 1);
            chk("a_init", bus.init_done, c >= 43);
            chk("a_own", bus.own_bus,
                c < 43 || (c >= 144 && c < 153) || (c >= 244 && c < 253));
            chk("a_req", bus.ref_req, c == 143 || c == 243);
            chk("a_done", bus.ref_done, c == 153 || c == 253);
            if (c == 20) chk("a_pre_a", bus.a, 13'h0400);
            if (c == 41) chk("a_lmr_a", bus.a, 13'h030);
            if (c == 41) chk("a_lmr_ba", bus.ba, 0);
        end

        // Reset in the middle of the first REFRESH wait.
        do_reset();
        while (cyc < 30) tick();
        chk("b_pre_rst_cke", bus.cke, 1);
        rstn = 1'b0;
        #1;
        chk("b_rst_cmd", bus.cmd, CMD_NOP);
        chk("b_rst_cke", bus.cke, 0);
        chk("b_rst_init", bus.init_done, 0);
        chk("b_rst_own", bus.own_bus, 1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc = -1;
        for (int c = 0; c <= 25; c++) begin
            tick();
            chk("b_cmd", bus.cmd, init_cmd(c));
        end

        // Grant withheld 350 cycles after init: backlog of three.
        bus.ref_gnt = 1'b0;
        do_reset();
        for (int c = 0; c <= 440; c++) begin
            tick();
            e = init_cmd(c);
            if (c == 394 || c == 404 || c == 414) e = CMD_REF;
            chk("c_cmd", bus.cmd, e);
            chk("c_done", bus.ref_done, c == 403 || c == 413 || c == 423);
            chk("c_ovr", bus.ref_overrun, 0);
            if (c >= 44 && c <= 393) chk("c_req", bus.ref_req, c >= 143);
            if (c >= 424) chk("c_req_end", bus.ref_req, 0);
            if (c == 393) bus.ref_gnt = 1'b1;
        end

        // Grant withheld 800 cycles: overrun, then drain of seven.
        bus.ref_gnt = 1'b0;
        do_reset();
        nref = 0;
        ndone = 0;
        for (int c = 0; c <= 930; c++) begin
            tick();
            e = init_cmd(c);
            if (c >= 844 && c <= 904 && (c - 844) % 10 == 0) e = CMD_REF;
            chk("d_cmd", bus.cmd, e);
            chk("d_ovr", bus.ref_overrun, c >= 842);
            if (c >= 44 && bus.cmd == CMD_REF) nref++;
            if (bus.ref_done) ndone++;
            if (c >= 914) chk("d_req_end", bus.ref_req, 0);
            if (c == 843) bus.ref_gnt = 1'b1;
        end
        chk("d_nref", nref, 7);
        chk("d_ndone", ndone, 7);

        // Grant lands on the expiry edge: no refresh lost or added.
        bus.ref_gnt = 1'b0;
        do_reset();
        for (int c = 0; c <= 345; c++) begin
            tick();
            e = init_cmd(c);
            if (c == 242 || c == 252 || c == 344) e = CMD_REF;
            chk("e_cmd", bus.cmd, e);
            chk("e_done", bus.ref_done, c == 251 || c == 261);
            if (c >= 44)
                chk("e_req", bus.ref_req,
                    (c >= 143 && c <= 241) || c == 251 || c == 343);
            if (c == 241) bus.ref_gnt = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
